// File: rtl/reg_file_mp.sv
// Multi-port register file: two write ports, two combinational read ports,
// optional hardwired-zero r0, optional write-to-read bypass and pending scoreboard.
module reg_file_mp #(
  parameter int DW      = 8,
  parameter int AW      = 3,
  parameter int ZERO_R0 = 1,
  parameter int BYPASS  = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wa_en,
  input  logic [AW-1:0] wa_addr,
  input  logic [DW-1:0] wa_dat,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_addr,
  input  logic [DW-1:0] wb_dat,
  input  logic          claim_en,
  input  logic [AW-1:0] claim_addr,
  input  logic [AW-1:0] rd_addrA,
  input  logic [AW-1:0] rd_addrB,
  output logic [DW-1:0] datA_out,
  output logic [DW-1:0] datB_out,
  output logic          busyA,
  output logic          busyB,
  output logic [AW:0]   pend_cnt
);

  localparam int DEPTH = 1 << AW;

  logic [DW-1:0]    core_q [DEPTH];
  logic [DW-1:0]    core_d [DEPTH];
  logic [DEPTH-1:0] pend_q, pend_d;
  logic [AW:0]      pend_cnt_q, pend_cnt_d;

  logic wa_ok, wb_ok, claim_ok;

  // Address 0 is inert (no writes, no claims) when it is hardwired to zero.
  always_comb begin
    wa_ok    = wa_en    && !(ZERO_R0 != 0 && wa_addr    == '0);
    wb_ok    = wb_en    && !(ZERO_R0 != 0 && wb_addr    == '0);
    claim_ok = claim_en && !(ZERO_R0 != 0 && claim_addr == '0);
  end

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    core_d = core_q;
    if (wa_ok) core_d[wa_addr] = wa_dat;
    // Port B is applied last so it wins a same-address collision.
    if (wb_ok) core_d[wb_addr] = wb_dat;
  end

  always_comb begin
    pend_d = pend_q;
    if (wa_ok) pend_d[wa_addr] = 1'b0;
    if (wb_ok) pend_d[wb_addr] = 1'b0;
    // A claim issued alongside a writeback refers to a newer producer.
    if (claim_ok) pend_d[claim_addr] = 1'b1;
  end

  always_comb begin
    pend_cnt_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_cnt_d = pend_cnt_d + (AW+1)'(pend_d[i]);
    end
  end

  // NOTE: the storage array is reset along with the scoreboard because reads
  // must return 0 as soon as reset asserts, so it cannot map to a plain RAM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        core_q[i] <= '0;
      end
      pend_q     <= '0;
      pend_cnt_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // sample their _d values from before the edge.
      core_q     <= core_d;
      pend_q     <= pend_d;
      pend_cnt_q <= pend_cnt_d;
    end
  end

  assign pend_cnt = pend_cnt_q;

  logic [AW-1:0] rd_addr [2];
  logic [DW-1:0] rd_dat  [2];
  logic          rd_busy [2];

  assign rd_addr[0] = rd_addrA;
  assign rd_addr[1] = rd_addrB;

  for (genvar p = 0; p < 2; p++) begin : g_rd
    logic hit_wa, hit_wb, is_zero;

    always_comb begin
      hit_wa  = (BYPASS != 0) && wa_en && (wa_addr == rd_addr[p]);
      hit_wb  = (BYPASS != 0) && wb_en && (wb_addr == rd_addr[p]);
      is_zero = (ZERO_R0 != 0) && (rd_addr[p] == '0);

      rd_dat[p]  = core_q[rd_addr[p]];
      if (hit_wb)      rd_dat[p] = wb_dat;
      else if (hit_wa) rd_dat[p] = wa_dat;

      // A value being forwarded this cycle is already available.
      rd_busy[p] = pend_q[rd_addr[p]] && !(hit_wa || hit_wb);

      // Bypass data comes straight from the inputs, so reset must mask it too.
      if (!rst_n || is_zero) begin
        rd_dat[p]  = '0;
        rd_busy[p] = 1'b0;
      end
    end
  end

  assign datA_out = rd_dat[0];
  assign datB_out = rd_dat[1];
  assign busyA    = rd_busy[0];
  assign busyB    = rd_busy[1];

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: bypass and non-bypass instances share one stimulus
// stream and are compared against an array-based reference model.
module tb_reg_file_mp;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wa_en, wb_en, claim_en;
  logic [AW-1:0] wa_addr, wb_addr, claim_addr, rd_addrA, rd_addrB;
  logic [DW-1:0] wa_dat, wb_dat;

  logic [DW-1:0] b_datA, b_datB, n_datA, n_datB;
  logic          b_busyA, b_busyB, n_busyA, n_busyB;
  logic [AW:0]   b_cnt, n_cnt;

  int tests_run = 0;
  int failed    = 0;

  // Reference state
  logic [DW-1:0] m_mem  [DEPTH];
  logic          m_pend [DEPTH];

  always #5 clk = ~clk;

  reg_file_mp #(.DW(DW), .AW(AW), .ZERO_R0(1), .BYPASS(1)) u_dut_byp (
    .clk(clk), .rst_n(rst_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_dat(wa_dat),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_dat(wb_dat),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(b_datA), .datB_out(b_datB),
    .busyA(b_busyA), .busyB(b_busyB), .pend_cnt(b_cnt)
  );

  reg_file_mp #(.DW(DW), .AW(AW), .ZERO_R0(1), .BYPASS(0)) u_dut_nob (
    .clk(clk), .rst_n(rst_n),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_dat(wa_dat),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_dat(wb_dat),
    .claim_en(claim_en), .claim_addr(claim_addr),
    .rd_addrA(rd_addrA), .rd_addrB(rd_addrB),
    .datA_out(n_datA), .datB_out(n_datB),
    .busyA(n_busyA), .busyB(n_busyB), .pend_cnt(n_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_mem[i]  = '0;
      m_pend[i] = 1'b0;
    end
  endfunction

  // Register 0 never stores or claims anything.
  function automatic void model_clock();
    if (wa_en && wa_addr != 0) begin m_mem[wa_addr] = wa_dat; m_pend[wa_addr] = 1'b0; end
    if (wb_en && wb_addr != 0) begin m_mem[wb_addr] = wb_dat; m_pend[wb_addr] = 1'b0; end
    if (claim_en && claim_addr != 0) m_pend[claim_addr] = 1'b1;
  endfunction

  function automatic int model_cnt();
    int n = 0;
    for (int i = 0; i < DEPTH; i++) n += int'(m_pend[i]);
    return n;
  endfunction

  function automatic logic [DW-1:0] model_dat(input logic [AW-1:0] a, input bit byp);
    if (!rst_n || a == 0) return '0;
    if (byp && wb_en && wb_addr == a) return wb_dat;
    if (byp && wa_en && wa_addr == a) return wa_dat;
    return m_mem[a];
  endfunction

  function automatic logic model_busy(input logic [AW-1:0] a, input bit byp);
    bit fwd;
    if (!rst_n || a == 0) return 1'b0;
    fwd = byp && ((wa_en && wa_addr == a) || (wb_en && wb_addr == a));
    return m_pend[a] && !fwd;
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".b_datA"},  32'(b_datA),  32'(model_dat(rd_addrA, 1)));
    check({tag, ".b_datB"},  32'(b_datB),  32'(model_dat(rd_addrB, 1)));
    check({tag, ".n_datA"},  32'(n_datA),  32'(model_dat(rd_addrA, 0)));
    check({tag, ".n_datB"},  32'(n_datB),  32'(model_dat(rd_addrB, 0)));
    check({tag, ".b_busyA"}, 32'(b_busyA), 32'(model_busy(rd_addrA, 1)));
    check({tag, ".b_busyB"}, 32'(b_busyB), 32'(model_busy(rd_addrB, 1)));
    check({tag, ".n_busyA"}, 32'(n_busyA), 32'(model_busy(rd_addrA, 0)));
    check({tag, ".n_busyB"}, 32'(n_busyB), 32'(model_busy(rd_addrB, 0)));
    check({tag, ".b_cnt"},   32'(b_cnt),   32'(model_cnt()));
    check({tag, ".n_cnt"},   32'(n_cnt),   32'(model_cnt()));
  endtask

  // Drive one cycle from a negedge, check combinational outputs, clock the model.
  task automatic step(input string tag,
                      input logic a_en, input logic [AW-1:0] a_ad, input logic [DW-1:0] a_d,
                      input logic b_en, input logic [AW-1:0] b_ad, input logic [DW-1:0] b_d,
                      input logic c_en, input logic [AW-1:0] c_ad,
                      input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    wa_en = a_en; wa_addr = a_ad; wa_dat = a_d;
    wb_en = b_en; wb_addr = b_ad; wb_dat = b_d;
    claim_en = c_en; claim_addr = c_ad;
    rd_addrA = ra; rd_addrB = rb;
    #1;
    check_all(tag);
    @(posedge clk);
    model_clock();
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input logic [AW-1:0] ra, input logic [AW-1:0] rb);
    step(tag, 0, 0, 0, 0, 0, 0, 0, 0, ra, rb);
  endtask

  initial begin
    rst_n = 1'b0;
    {wa_en, wb_en, claim_en} = '0;
    {wa_addr, wb_addr, claim_addr, rd_addrA, rd_addrB} = '0;
    wa_dat = '0; wb_dat = '0;
    model_reset();
    #12;
    rd_addrA = 3; rd_addrB = 6;
    #1;
    check_all("reset_init");
    @(negedge clk);
    rst_n = 1'b1;

    // Fill r1..r7 with FF while claiming each; claim wins, so all 7 go pending.
    for (int r = 1; r < DEPTH; r++) begin
      step("fill", 1, AW'(r), 8'hFF, 0, 0, 0, 1, AW'(r), AW'(r), AW'(r - 1));
    end
    idle("fill_full", 3, 7);
    check("pend_cnt_max", 32'(b_cnt), 32'(DEPTH - 1));

    // Mid-cycle reset with live writes on the inputs.
    wa_en = 1; wa_addr = 3; wa_dat = 8'hFF;
    wb_en = 1; wb_addr = 5; wb_dat = 8'hFF;
    claim_en = 1; claim_addr = 6;
    rd_addrA = 3; rd_addrB = 5;
    #1;
    rst_n = 1'b0;
    model_reset();
    #1;
    check_all("reset_mid");
    check("reset_mid_datA", 32'(b_datA), 32'h0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle("after_reset", 3, 5);

    // Register 0 is hardwired zero.
    step("r0_wr", 1, 0, 8'hA5, 0, 0, 0, 1, 0, 0, 0);
    idle("r0_after", 0, 0);

    // Write collision: port B wins.
    step("coll", 1, 3, 8'h11, 1, 3, 8'h22, 0, 0, 3, 3);
    idle("coll_after", 3, 0);
    check("coll_r3", 32'(b_datA), 32'h22);

    // Bypass vs. registered read.
    step("byp", 1, 5, 8'h3C, 0, 0, 0, 0, 0, 5, 5);
    idle("byp_after", 5, 5);

    // Scoreboard: claim then writeback.
    step("sb_claim", 0, 0, 0, 0, 0, 0, 1, 2, 2, 0);
    step("sb_write", 1, 2, 8'h7E, 0, 0, 0, 0, 0, 2, 0);
    idle("sb_after", 2, 0);

    // Claim and write to the same register in one cycle.
    step("cw", 0, 0, 0, 1, 4, 8'h99, 1, 4, 0, 4);
    idle("cw_after", 0, 4);
    check("cw_busyB", 32'(b_busyB), 32'h1);

    // Randomized traffic.
    for (int i = 0; i < 300; i++) begin
      step("rand",
           1'($urandom), AW'($urandom), DW'($urandom),
           1'($urandom), AW'($urandom), DW'($urandom),
           1'($urandom_range(0, 2) == 0), AW'($urandom),
           AW'($urandom), AW'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the datapath: two write ports, two combinational read ports.
- Register 0 is optionally hardwired to zero.
- Optional write-to-read bypass.
- Per-register pending (scoreboard) bits let the control unit detect reads of registers whose producer has not yet written back.

Parameters:
DW, 8, data width of each register
AW, 3, address width; depth = 2**AW registers
ZERO_R0, 1, 1 = register 0 reads as 0, ignores writes and claims
BYPASS, 1, 1 = read ports forward same-cycle write data

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
wa_en  in  1  write port A enable
wa_addr  in  AW  write port A address
wa_dat  in  DW  write port A data
wb_en  in  1  write port B enable
wb_addr  in  AW  write port B address
wb_dat  in  DW  write port B data
claim_en  in  1  mark register claim_addr pending
claim_addr  in  AW  register being claimed by an issued producer
rd_addrA  in  AW  read address A
rd_addrB  in  AW  read address B
datA_out  out  DW  read data A (combinational)
datB_out  out  DW  read data B (combinational)
busyA  out  1  register at rd_addrA is pending
busyB  out  1  register at rd_addrB is pending
pend_cnt  out  AW+1  number of pending registers

Behaviour:
- Reset:
  - Asynchronous reset: rst_n low immediately clears every register to 0 and every pending bit to 0; held while rst_n low.
  - With reset asserted, datA_out = datB_out = 0, busyA = busyB = 0, pend_cnt = 0.
  - Reset mid-operation discards in-flight writes and claims of that cycle.
- Writes:
  - At posedge, each enabled write port stores its data into core[addr].
  - Both ports enabled to the same address: port B wins.
  - ZERO_R0 = 1: writes to address 0 are dropped.
- Pending bits:
  - At posedge, an enabled write (either port) to address r clears pend[r].
  - claim_en to address r sets pend[r].
  - Claim and write to the same r in the same cycle: claim wins, pend[r] = 1, and the data is still written.
  - Claim to an already-pending register leaves it at 1.
  - ZERO_R0 = 1: pend[0] is constant 0.
- Reads:
  - Combinational, zero latency.
  - Base value is core[rd_addr].
  - BYPASS = 1: if wb_en and wb_addr == rd_addr, output wb_dat; else if wa_en and wa_addr == rd_addr, output wa_dat; else core.
  - BYPASS = 0: output reflects the write only from the cycle after the posedge.
  - ZERO_R0 = 1 and rd_addr == 0: output 0 regardless of bypass.
- Busy outputs:
  - busyX = pend[rd_addrX] & ~(BYPASS & a write to rd_addrX this cycle). A bypassed value is not busy.
  - Always 0 for address 0 when ZERO_R0 = 1.
- pend_cnt:
  - Registered population count of pend, updated at the same edge as pend.
  - Range 0..2**AW; max 2**AW - 1 when ZERO_R0 = 1.
- Widths: all addresses are exactly AW bits, so no out-of-range addresses exist. No arithmetic on data.

Test Plan:
- Reset check: run writes to r1..r7 with 8'hFF, then assert rst_n low mid-cycle -> all reads return 8'h00 immediately, pend_cnt = 0, busyA = busyB = 0.
- Register 0 (ZERO_R0 = 1): write wa r0 = 8'hA5, claim r0 -> datA_out(r0) = 8'h00 before and after the edge, busyA = 0, pend_cnt = 0.
- Write collision: wa r3 = 8'h11 and wb r3 = 8'h22 in the same cycle -> next cycle r3 reads 8'h22. With BYPASS = 1, the same-cycle read of r3 also returns 8'h22.
- Bypass toggle: wa r5 = 8'h3C, read r5 the same cycle -> BYPASS = 1 returns 8'h3C; BYPASS = 0 returns the old value 8'h00, then 8'h3C the following cycle.
- Scoreboard sequence:
  - Claim r2 -> next cycle busyA = 1 (rd_addrA = 2), pend_cnt = 1.
  - Write r2 = 8'h7E -> with BYPASS = 1, busyA = 0 that cycle; next cycle pend_cnt = 0 and datA_out = 8'h7E.
- Claim/write same cycle: claim r4 while wb writes r4 = 8'h99 -> next cycle r4 = 8'h99, pend[4] = 1, busyB = 1 (rd_addrB = 4), pend_cnt increments by 1.
